// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multicycle LEGv8-subset core: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module legv8_multicycle_control #(
    parameter int CNT_W = 32,
    parameter int OPC_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             reg2loc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_LD  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        HALT   = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    logic is_rtype, is_ldur, is_stur, is_cbz, is_b;

    assign is_rtype = (opcode_i[10:0] == 11'b10001011000) ||
                      (opcode_i[10:0] == 11'b11001011000) ||
                      (opcode_i[10:0] == 11'b10001010000) ||
                      (opcode_i[10:0] == 11'b10101010000);
    assign is_ldur  = (opcode_i[10:0] == 11'b11111000010);
    assign is_stur  = (opcode_i[10:0] == 11'b11111000000);
    assign is_cbz   = (opcode_i[10:3] == 8'b10110100);
    assign is_b     = (opcode_i[10:5] == 6'b000101);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Every exit back to FETCH from a completing state retires one instruction.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            INIT:   state_d = FETCH;
            FETCH:  if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                if (is_rtype)                state_d = EXEC_R;
                else if (is_ldur || is_stur) state_d = ADDR;
                else if (is_cbz)             state_d = BRANCH;
                else if (is_b)               state_d = JUMP;
                else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC_R: state_d = WB_R;
            WB_R:   begin state_d = FETCH; retire = 1'b1; end
            ADDR:   state_d = is_ldur ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_ready_i) state_d = WB_LD;
            WB_LD:  begin state_d = FETCH; retire = 1'b1; end
            MEM_WR: if (mem_ready_i) begin state_d = FETCH; retire = 1'b1; end
            BRANCH: begin state_d = FETCH; retire = 1'b1; end
            JUMP:   begin state_d = FETCH; retire = 1'b1; end
            HALT:   state_d = HALT;
            default: state_d = INIT;
        endcase
        count_d = retire ? count_q + {{(CNT_W-1){1'b0}}, 1'b1} : count_q;
    end

    always_comb begin
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        reg2loc_o    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                reg2loc_o   = is_stur || is_cbz;
            end
            EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            WB_R:   reg_write_o = 1'b1;
            ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            WB_LD: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                reg2loc_o   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                reg2loc_o   = 1'b1;
                pc_src_o    = 2'b01;
                pc_write_o  = zero_i;
            end
            JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_o     = illegal_q;
    assign instr_count_o = count_q;
    assign state_o       = state_q;

endmodule
